bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Two-master arbiter for the serial system bus.
- Takes approval requests from both master ports and issues exactly one approval grant at a time.
- Drives a busy indication to the master that is not granted, and a select that steers the shared bus muxes.
- Releases the bus on transaction done, on request withdrawal, or on a watchdog timeout.
- Ties are broken round-robin.

Parameters:
- TIMEOUT_CYCLES, 4096: maximum cycles a master may own the bus; 0 disables the watchdog.
- CNT_LEN, 13: width of the ownership counter; must satisfy 2^CNT_LEN > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- m1_request  input  1  approval_request from master 1.
- m2_request  input  1  approval_request from master 2.
- m1_done  input  1  transaction-complete pulse from master 1 side (tx_done/rx_done OR).
- m2_done  input  1  transaction-complete pulse from master 2 side.
- m1_grant  output  1  approval_grant to master 1.
- m2_grant  output  1  approval_grant to master 2.
- m1_busy  output  1  busy to master 1 (bus held by, or handing over from, master 2).
- m2_busy  output  1  busy to master 2.
- bus_sel  output  1  bus mux select: 0 = master 1 drives, 1 = master 2 drives.
- bus_idle  output  1  high when no master owns the bus.
- timeout  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, last_owner=M2, counter=0.
  - Output values: m1_grant=0, m2_grant=0, m1_busy=0, m2_busy=0, bus_sel=0, bus_idle=1, timeout=0.
  - Asserting reset mid-transaction drops the grant immediately, without waiting for a clock edge.
- States:
  - IDLE: no owner.
  - M1_OWN / M2_OWN: the named master is granted.
  - RELEASE: one turnaround cycle with both grants low.
- Arbitration in IDLE or RELEASE:
  - Only one master requesting: that master is granted.
  - Both requesting: the master that is not last_owner is granted.
  - After reset, a tie therefore goes to M1.
  - Neither requesting: next state is IDLE.
- Latency:
  - Request seen high at edge N in IDLE: the grant is high after edge N (registered, 1 cycle).
  - Handover from an owner through RELEASE to the next grant takes 2 cycles.
- Entering Mx_OWN: last_owner=x, bus_sel=x (0 for M1, 1 for M2), counter cleared.
- bus_sel holds its value in IDLE and RELEASE.
- Mx_OWN to RELEASE on any of these, sampled at the edge:
  - mx_done=1;
  - mx_request=0;
  - counter==TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES!=0.
- On the watchdog exit, timeout pulses high for exactly the first RELEASE cycle.
- If done and the timeout condition coincide, done wins and timeout stays 0.
- Counter:
  - Increments every cycle in Mx_OWN.
  - Saturates, never wraps.
  - Is cleared in IDLE and RELEASE.
- Busy and idle outputs:
  - m1_busy = (M2_OWN or (RELEASE and last_owner=M2)).
  - m2_busy is symmetric.
  - bus_idle = (state==IDLE or RELEASE).
- Ignored inputs:
  - Requests from the non-owner during Mx_OWN are ignored; the requester sees busy=1 and must hold its request.
  - mx_done from a non-owner is ignored.
  - mx_done in IDLE is ignored.
- Simultaneous events:
  - Owner done while the other master is requesting: RELEASE, then the other master is granted.
  - Owner drops request while re-requesting in RELEASE along with the other master: the other master wins (round-robin).
  - Owner re-requesting alone in RELEASE: the owner is re-granted.
- m1_grant and m2_grant are never both high; a bench assertion checks this every cycle.

Test Plan:
- Reset, then m1_request=1 at cycle 2:
  - m1_grant=1 from cycle 3, m2_busy=1, bus_sel=0, bus_idle=0.
  - m1_done pulse at cycle 10: m1_grant=0 at cycle 11 (RELEASE), bus_idle=1 at cycle 11.
- Both requests rise on the same edge after reset:
  - M1 is granted first.
  - After m1_done, m2_grant=1 two cycles later, bus_sel=1.
  - A new tie then goes to M1 again (alternation verified over 4 transactions).
- m2 owns the bus and m1_request rises mid-transaction:
  - m1_busy=1 and m1_grant=0 for the whole ownership.
  - m1_grant=1 exactly 2 cycles after m2_done.
- TIMEOUT_CYCLES=8, m1 holds its request with no done:
  - m1_grant is high for exactly 8 cycles.
  - timeout=1 for one cycle in RELEASE.
  - m1 is re-granted on the next cycle.
  - With TIMEOUT_CYCLES=0 and the same stimulus, the grant holds for 10000 cycles and timeout stays 0.
- Owner deasserts request without done: bus is released identically to done, and timeout=0.
- reset pulled low mid-ownership (between edges):
  - m1_grant and m2_busy fall immediately.
  - After reset release with both requesting, M1 is granted first.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bundle between two bus masters and the arbiter
//
// Purpose: groups the handshake between the two serial-bus masters and bus_arbiter.
// Signals:
//   m1_request, m2_request : approval requests from master 1 / master 2
//   m1_done, m2_done       : transaction-complete pulses from each master side
//   m1_grant, m2_grant     : approval grants (never both high)
//   m1_busy, m2_busy       : bus held by, or handing over from, the other master
//   bus_sel                : shared-mux select, 0 = master 1 drives, 1 = master 2 drives
//   bus_idle               : no master owns the bus
//   timeout                : one-cycle pulse when the watchdog forces a release
// Modports: master (request side), slave (arbiter side).
interface bus_arbiter_if;
  logic m1_request;
  logic m2_request;
  logic m1_done;
  logic m2_done;
  logic m1_grant;
  logic m2_grant;
  logic m1_busy;
  logic m2_busy;
  logic bus_sel;
  logic bus_idle;
  logic timeout;

  modport master (
    output m1_request, m2_request, m1_done, m2_done,
    input  m1_grant, m2_grant, m1_busy, m2_busy, bus_sel, bus_idle, timeout
  );

  modport slave (
    input  m1_request, m2_request, m1_done, m2_done,
    output m1_grant, m2_grant, m1_busy, m2_busy, bus_sel, bus_idle, timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter with ownership watchdog
//
// Purpose: grants the serial system bus to one of two masters at a time, with a
// one-cycle turnaround between owners and a watchdog that forces a release.
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : bus_arbiter_if.slave (requests/done in; grants, busy, select, idle, timeout out)
// Parameters:
//   TIMEOUT_CYCLES : maximum cycles a master may own the bus, 0 disables the watchdog
//   CNT_LEN        : ownership counter width, 2**CNT_LEN must exceed TIMEOUT_CYCLES
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_LEN        = 13
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    M1_OWN  = 2'd1,
    M2_OWN  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam bit                 WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_LEN-1:0] CNT_LAST = CNT_LEN'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_LEN-1:0] CNT_MAX  = '1;

  state_t             state, state_nxt;
  logic               last_owner, last_owner_nxt;  // 0 = M1, 1 = M2
  logic               sel, sel_nxt;
  logic [CNT_LEN-1:0] cnt, cnt_nxt;
  logic               to_q, to_nxt;
  logic               own_req, own_done, wdog_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      sel        <= 1'b0;
      cnt        <= '0;
      to_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      sel        <= sel_nxt;
      cnt        <= cnt_nxt;
      to_q       <= to_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    sel_nxt        = sel;
    cnt_nxt        = '0;      // cleared in IDLE/RELEASE and on entry to ownership
    to_nxt         = 1'b0;
    own_req        = (state == M2_OWN) ? bus.m2_request : bus.m1_request;
    own_done       = (state == M2_OWN) ? bus.m2_done : bus.m1_done;
    wdog_hit       = WDOG_EN && (cnt == CNT_LAST);

    case (state)
      IDLE, RELEASE: begin
        // On a tie the master that did not own the bus last wins.
        if (bus.m1_request && (!bus.m2_request || last_owner)) begin
          state_nxt      = M1_OWN;
          last_owner_nxt = 1'b0;
          sel_nxt        = 1'b0;
        end else if (bus.m2_request) begin
          state_nxt      = M2_OWN;
          last_owner_nxt = 1'b1;
          sel_nxt        = 1'b1;
        end else begin
          state_nxt      = IDLE;
        end
      end
      M1_OWN, M2_OWN: begin
        if (own_done || !own_req) begin
          // A regular release takes priority over a coincident watchdog expiry.
          state_nxt = RELEASE;
        end else if (wdog_hit) begin
          state_nxt = RELEASE;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CNT_LEN'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.m1_grant = (state == M1_OWN);
  assign bus.m2_grant = (state == M2_OWN);
  assign bus.m1_busy  = (state == M2_OWN) || ((state == RELEASE) && last_owner);
  assign bus.m2_busy  = (state == M1_OWN) || ((state == RELEASE) && !last_owner);
  assign bus.bus_sel  = sel;
  assign bus.bus_idle = (state == IDLE) || (state == RELEASE);
  assign bus.timeout  = to_q;

endmodule
